echo_delay_line: RTL
====================

Name: echo_delay_line

Overview:
- Programmable circular-buffer delay line for 16-bit audio samples in the echo path.
- Sits directly upstream of the gain stage and supplies the delayed sample that the gain stage attenuates before mixing.
- Mutes its output until enough history exists for the requested delay, so the echo path never emits stale RAM contents.

Parameters:
- DATA_W, 16, sample width (signed two's complement).
- ADDR_W, 10, buffer address width; depth = 2^ADDR_W = 1024 samples; maximum usable delay = 1023.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sample_in  in  DATA_W  incoming sample.
- sample_valid  in  1  one-cycle strobe; sample_in is valid this cycle.
- delay_len  in  ADDR_W  requested delay in samples; sampled only on sample_valid cycles.
- delayed_out  out  DATA_W  delayed sample, feeds the gain stage's integer input.
- delayed_valid  out  1  one-cycle strobe marking delayed_out.
- primed  out  1  high once fill count >= current delay, i.e. the output is real audio.

Behaviour:
- Reset is asynchronous and active-low. All state clears on reset.
  - Reset values: wr_ptr=0, fill_cnt=0, state=FILL, delayed_out=0, delayed_valid=0, primed=0.
  - RAM contents are not cleared.
- On each sample_valid:
  - Write sample_in at wr_ptr; wr_ptr increments modulo 2^ADDR_W (wraps 1023->0).
  - Issue a read at rd_addr = (wr_ptr - delay_len) mod 2^ADDR_W, computed in ADDR_W bits.
  - fill_cnt increments, saturating at 2^ADDR_W-1.
- Latency: delayed_valid asserts exactly 1 cycle after sample_valid (synchronous RAM read, registered output). One output strobe per input strobe; there is no backpressure.
- delay_len=0: delayed_out equals the sample_in of the same strobe. RAM read/write collision is resolved by a bypass mux, not by RAM read-during-write behaviour.
- State machine (2 states):
  - FILL: delayed_out=0 on every strobe. Go to RUN when, on a sample_valid cycle, fill_cnt (pre-increment) >= delay_len. The strobe that causes the transition already outputs real data.
  - RUN: delayed_out = RAM/bypass data; primed=1. Return to FILL only on reset, or per the optional feature.
- delay_len increased in RUN beyond fill_cnt (only possible before saturation): output 0 for those strobes. State stays RUN. primed follows fill_cnt >= delay_len combinationally, registered with the output.
- sample_valid on back-to-back cycles is supported at full rate.
- Reset asserted mid-stream: output strobe in flight is discarded; delayed_valid=0 immediately.

Optional Feature:
- Macro ECHO_DELAY_FLUSH_EN.
- Defined:
  - The block registers the delay_len captured on the last strobe.
  - On a strobe whose delay_len differs from it, fill_cnt is reset to 1 (the current write counts), state returns to FILL, and primed drops. Output mutes until re-primed, which avoids discontinuity clicks on delay changes.
- Undefined:
  - delay changes take effect immediately with no re-priming; only the fill_cnt rule above applies.

Decomposition:
- Package echo_pkg:
  - DATA_W and ADDR_W defaults.
  - State enum type (FILL, RUN).
  - Sample typedef (signed DATA_W).
  - Constant MAX_DELAY = 2^ADDR_W-1.
- One sub-module, echo_ram: simple dual-port synchronous RAM (one write port, one registered read port), so the buffer maps to block RAM.
- Pointer, fill, bypass and FSM logic live in echo_delay_line.

Test Plan:
- Reset, then delay_len=4; feed ramp 1,2,3,...,10 on consecutive strobes -> delayed_out 0,0,0,0,1,2,3,4,5,6. primed rises with the 5th output. Each delayed_valid is 1 cycle after its strobe.
- delay_len=0; feed 0x7FFF, 0x8000, 0x1234 -> outputs identical, 1-cycle latency, primed=1 from the first strobe.
- delay_len=1023; feed 2100 samples with value = index -> first 1023 outputs 0. Output n = n-1023 afterwards, confirming correct wr_ptr wrap past 1023->0.
- Strobes spaced 3 idle cycles apart vs back-to-back, delay 2 -> identical output sequences. delayed_valid count equals sample_valid count.
- In RUN with delay 8, assert reset_n low for 1 cycle mid-stream -> all outputs 0 immediately. Next 8 outputs after release are 0.
- ECHO_DELAY_FLUSH_EN defined:
  - Change delay 4->6 mid-stream -> primed drops on that strobe, then 6 muted outputs, then correct 6-delayed data.
  - Undefined: output switches to 6-delayed data on the next strobe with no mute.

Source files
------------

// File: rtl/echo_pkg.sv
// echo_pkg: shared definitions for the echo delay line.
//   DATA_W_DEF / ADDR_W_DEF : default sample and buffer address widths
//   MAX_DELAY               : largest usable delay for the default buffer
//   echo_state_t            : priming state machine states (FILL, RUN)
//   sample_t                : signed audio sample type
`timescale 1ns/1ps
package echo_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;
    localparam int MAX_DELAY  = (1 << ADDR_W_DEF) - 1;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } echo_state_t;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;
endpackage

// File: rtl/echo_ram.sv
// echo_ram: simple dual-port synchronous RAM backing the delay buffer.
// One write port, one read port with a registered output, no reset on the
// storage so it maps onto block RAM.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; rd_data updates on the next edge only when set
//   rd_addr  : read address
//   rd_data  : registered read data (holds between reads)
`timescale 1ns/1ps
module echo_ram
    import echo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/echo_delay_line.sv
// echo_delay_line: programmable circular-buffer delay for the echo path.
// Every sample_valid strobe writes one sample and produces one delayed sample
// one cycle later. The output stays muted until the buffer holds at least
// delay_len samples written since reset, so stale RAM never reaches the gain stage.
// Optional build macro: ECHO_DELAY_FLUSH_EN -- when defined, any change of
// delay_len between strobes restarts the fill count and re-mutes the output.
// Ports:
//   clk           : clock
//   reset_n       : asynchronous active-low reset
//   sample_in     : incoming sample
//   sample_valid  : one-cycle input strobe
//   delay_len     : requested delay in samples (sampled with sample_valid)
//   delayed_out   : delayed sample (0 while muted)
//   delayed_valid : one-cycle strobe, one cycle after each sample_valid
//   primed        : output carries real audio (fill count >= delay)
`timescale 1ns/1ps
module echo_delay_line
    import echo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [ADDR_W-1:0] delay_len,
    output logic [DATA_W-1:0] delayed_out,
    output logic              delayed_valid,
    output logic              primed
);
    localparam logic [ADDR_W-1:0] FILL_MAX = '1;
    localparam logic [ADDR_W-1:0] FILL_ONE = ADDR_W'(1);

    echo_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] fill_cnt_reg, fill_cnt_next;
    logic              primed_reg, primed_next;
    logic              valid_reg, valid_next;
    logic              mute_reg, mute_next;
    logic              bypass_sel_reg, bypass_sel_next;
    logic [DATA_W-1:0] bypass_data_reg, bypass_data_next;
`ifdef ECHO_DELAY_FLUSH_EN
    logic [ADDR_W-1:0] last_delay_reg, last_delay_next;
`endif

    logic              flush;
    logic [ADDR_W-1:0] fill_eff;
    logic              have_hist;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] ram_rd_data;

    echo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (sample_valid),
        .wr_addr (wr_ptr_reg),
        .wr_data (sample_in),
        .rd_en   (sample_valid),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        flush = 1'b0;
`ifdef ECHO_DELAY_FLUSH_EN
        flush = sample_valid && (delay_len != last_delay_reg);
        last_delay_next = sample_valid ? delay_len : last_delay_reg;
`endif
        // A flushing strobe sees an empty history: only delay 0 is satisfiable.
        fill_eff  = flush ? '0 : fill_cnt_reg;
        have_hist = (fill_eff >= delay_len);
        // Modulo-2^ADDR_W subtraction wraps naturally in ADDR_W bits.
        rd_addr   = wr_ptr_reg - delay_len;

        state_next       = state_reg;
        wr_ptr_next      = wr_ptr_reg;
        fill_cnt_next    = fill_cnt_reg;
        primed_next      = primed_reg;
        mute_next        = mute_reg;
        bypass_sel_next  = bypass_sel_reg;
        bypass_data_next = bypass_data_reg;
        valid_next       = 1'b0;

        if (sample_valid) begin
            valid_next  = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            if (flush) begin
                fill_cnt_next = FILL_ONE;
            end else if (fill_cnt_reg != FILL_MAX) begin
                fill_cnt_next = fill_cnt_reg + 1'b1;
            end
            primed_next = have_hist;
            // Delay 0 reads the address being written this same cycle; the
            // RAM would return the old word, so take the sample directly.
            bypass_sel_next  = (delay_len == '0);
            bypass_data_next = sample_in;
            mute_next        = !have_hist;

            if (state_reg == FILL) begin
                // The strobe that completes priming already outputs real data.
                if (have_hist) begin
                    state_next = RUN;
                end
            end else begin
                // In RUN an over-long delay only mutes; leaving RUN needs a flush.
                if (flush && !have_hist) begin
                    state_next = FILL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= FILL;
            wr_ptr_reg      <= '0;
            fill_cnt_reg    <= '0;
            primed_reg      <= 1'b0;
            valid_reg       <= 1'b0;
            mute_reg        <= 1'b1;
            bypass_sel_reg  <= 1'b0;
            bypass_data_reg <= '0;
`ifdef ECHO_DELAY_FLUSH_EN
            last_delay_reg  <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            wr_ptr_reg      <= wr_ptr_next;
            fill_cnt_reg    <= fill_cnt_next;
            primed_reg      <= primed_next;
            valid_reg       <= valid_next;
            mute_reg        <= mute_next;
            bypass_sel_reg  <= bypass_sel_next;
            bypass_data_reg <= bypass_data_next;
`ifdef ECHO_DELAY_FLUSH_EN
            last_delay_reg  <= last_delay_next;
`endif
        end
    end

    assign delayed_out   = mute_reg       ? '0 :
                           bypass_sel_reg ? bypass_data_reg : ram_rd_data;
    assign delayed_valid = valid_reg;
    assign primed        = primed_reg;
endmodule
